ysyx_23060203_dec: RTL
======================

YSYX_23060203_DEC -- requirements
Module: ysyx_23060203_DEC

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL provide parameter NREG, default 32, GPR count; legal values 16 (RV32E) and 32.
REQ-003 SHALL provide derived localparam RA_W = $clog2(NREG), the register index width.
REQ-004 SHALL provide clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL provide in_valid  in  1  upstream instruction valid.
REQ-007 SHALL provide in_ready  out  1  decoder can accept.
REQ-008 SHALL provide in_inst  in  32  instruction word.
REQ-009 SHALL provide in_pc  in  XLEN  instruction PC.
REQ-010 SHALL provide flush  in  1  discard held and incoming instruction.
REQ-011 SHALL provide rf_raddr1 / rf_raddr2  out  RA_W  register-file read indices (rs1, rs2).
REQ-012 SHALL provide rf_rdata1 / rf_rdata2  in  XLEN  combinational register-file read data.
REQ-013 SHALL provide out_valid  out  1  decoded bundle valid.
REQ-014 SHALL provide out_ready  in  1  downstream accepts.
REQ-015 SHALL provide out_pc  out  XLEN;  out_rd  out  RA_W;  out_src1 / out_src2  out  XLEN;  out_imm  out  XLEN.
REQ-016 SHALL provide out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-017 SHALL provide out_opcode  out  7;  out_funct3  out  3;  out_funct7  out  7.
REQ-018 SHALL provide out_illegal  out  1  unsupported encoding.
REQ-019 SHALL provide halt  out  1  one-cycle pulse on ebreak retirement into the output register.
REQ-020 SHALL provide halted  out  1  level, decoder stopped.

Function
REQ-021 Pipeline register, latency 1: instruction accepted on cycle N (in_valid & in_ready) SHALL appear with out_valid=1 on cycle N+1.
REQ-022 in_ready SHALL equal !halted & (!out_valid | out_ready); combinational from out_ready.
REQ-023 rf_raddr1 = in_inst[15+:RA_W], rf_raddr2 = in_inst[20+:RA_W] combinationally; rf_rdata* SHALL be captured into out_src* at the accepting edge.
REQ-024 Held bundle SHALL remain stable while out_valid & !out_ready.
REQ-025 Accept and drain in same cycle SHALL replace the bundle with no bubble.
REQ-026 out_imm SHALL be sign-extended from inst[31] to XLEN per format: I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0}; U {31:12,12'b0}; J {31,19:12,20,30:21,0}; R → 0.
REQ-027 Format by opcode: 0110011→R; 0010011, 0000011, 1100111, 1110011→I; 0100011→S; 1100011→B; 0110111, 0010111→U; 1101111→J.
REQ-028 out_illegal SHALL be 1 for any other opcode, inst[1:0]≠2'b11, or (NREG=16 and any used rd/rs1/rs2 field bit 4 set).
REQ-029 Illegal instructions SHALL still pass through as a normal bundle; decoder does not stall on them.
REQ-030 States: RUN, HALTED; reset → RUN.
REQ-031 RUN→HALTED on accepting inst 32'h00100073; halt SHALL pulse the following cycle alongside that bundle's out_valid; halted=1 from that cycle.
REQ-032 In HALTED, in_ready=0; the ebreak bundle SHALL still drain normally; only rst leaves HALTED.
REQ-033 flush SHALL clear out_valid next cycle and block acceptance in the flush cycle; flush over an ebreak accept in the same cycle SHALL suppress the halt transition.
REQ-034 flush in HALTED SHALL clear out_valid but not leave HALTED.

Reset
REQ-035 On rst sampled high: out_valid=0, halt=0, halted=0, state=RUN; all data outputs 0.
REQ-036 rst SHALL override in_valid, flush and out_ready in the same cycle; in-flight bundle discarded.
REQ-037 in_ready SHALL be 0 during the rst cycle and 1 the cycle after.

Verification
REQ-038 addi x1,x0,5 (0x00500093), rf_rdata1=0 → next cycle out_fmt=1, out_rd=1, out_imm=5, out_src1=0, out_illegal=0.
REQ-039 sw x2,-4(x1) (0xFE20AE23), rdata1=0x100, rdata2=0xAB → out_fmt=2, out_imm=0xFFFFFFFC, out_src1=0x100, out_src2=0xAB.
REQ-040 out_ready=0 for 3 cycles with in_valid=1 → bundle stable, in_ready=0; release → back-to-back transfer with no bubble.
REQ-041 ebreak (0x00100073) accepted → halt=1 for exactly one cycle, halted stays 1, in_ready=0 until rst.
REQ-042 NREG=16, 0x00500893 (rd=17) → out_illegal=1; NREG=32 same word → out_illegal=0.
REQ-043 flush asserted with ebreak accept and a held bundle → out_valid=0 next cycle, halted=0, halt never pulses.

Source files
------------

// File: rtl/ysyx_23060203_dec.sv
// Single-stage RISC-V instruction decoder with valid/ready handshake, register-file
// operand capture and an ebreak halt state.
module ysyx_23060203_dec #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [RA_W-1:0] rf_raddr1,
    output logic [RA_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [RA_W-1:0] out_rd,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_illegal,
    output logic            halt,
    output logic            halted
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam bit          RV32E  = (NREG == 16);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic {RUN, HALTED} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            illegal;
    } bundle_t;

    state_e  state_q, state_d;
    logic    out_valid_q, out_valid_d;
    logic    halt_q, halt_d;
    bundle_t bundle_q, bundle_d;

    logic [2:0]         fmt;
    logic               known;
    logic               use_rd, use_rs1, use_rs2;
    logic               reg_oob;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    imm_ext;
    logic               accept;
    bundle_t            dec;

    assign rf_raddr1 = in_inst[15 +: RA_W];
    assign rf_raddr2 = in_inst[20 +: RA_W];

    always_comb begin
        fmt     = FMT_R;
        known   = 1'b1;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (in_inst[6:0])
            7'b0110011: begin
                fmt = FMT_R; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            7'b0100011: begin
                fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b1100011: begin
                fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                fmt = FMT_U; use_rd = 1'b1;
            end
            7'b1101111: begin
                fmt = FMT_J; use_rd = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: imm32 = {in_inst[31:12], 12'b0};
            FMT_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast widens to XLEN with sign replication for RV64 builds.
    assign imm_ext = XLEN'(imm32);

    // RV32E only has x0..x15, so bit 4 of any register field that is actually used is illegal.
    assign reg_oob = RV32E & ((use_rd & in_inst[11]) | (use_rs1 & in_inst[19]) |
                              (use_rs2 & in_inst[24]));

    always_comb begin
        dec.pc      = in_pc;
        dec.rd      = in_inst[7 +: RA_W];
        dec.src1    = rf_rdata1;
        dec.src2    = rf_rdata2;
        dec.imm     = imm_ext;
        dec.fmt     = fmt;
        dec.opcode  = in_inst[6:0];
        dec.funct3  = in_inst[14:12];
        dec.funct7  = in_inst[31:25];
        dec.illegal = !known | (in_inst[1:0] != 2'b11) | reg_oob;
    end

    assign in_ready = !rst && (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        halt_d      = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
            if (in_inst == EBREAK) begin
                state_d = HALTED;
                halt_d  = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            halt_q      <= 1'b0;
            bundle_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            halt_q      <= halt_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = bundle_q.pc;
    assign out_rd      = bundle_q.rd;
    assign out_src1    = bundle_q.src1;
    assign out_src2    = bundle_q.src2;
    assign out_imm     = bundle_q.imm;
    assign out_fmt     = bundle_q.fmt;
    assign out_opcode  = bundle_q.opcode;
    assign out_funct3  = bundle_q.funct3;
    assign out_funct7  = bundle_q.funct7;
    assign out_illegal = bundle_q.illegal;
    assign halt        = halt_q;
    assign halted      = (state_q == HALTED);

endmodule
